// File: rtl/pmod_als_spi_emulator.sv
// Pmod ALS (ADC081S021-style) SPI slave emulator.
// Oversamples the master's cs/sck on the system clock and shifts out a
// framed light sample: leading zeros, sample MSB first, trailing zeros.
module pmod_als_spi_emulator #(
  parameter int DATA_WIDTH = 8,
  parameter int LEAD_ZEROS = 3,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  output logic                  sdo,
  output logic                  sdo_oe,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort
);

  localparam int TRAIL = FRAME_LEN - LEAD_ZEROS - DATA_WIDTH;
  localparam int CW    = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic cs_m_q, cs_s_q, cs_h_q;
  logic sck_m_q, sck_s_q, sck_h_q;
  logic [1:0] settle_q;
  logic arm_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic done_q, done_d, abort_q, abort_d;

  logic cs_fall, cs_rise, sck_fall;
  logic [DATA_WIDTH-1:0] load_src;
  logic [FRAME_LEN-1:0] frame_word;
  logic [CW-1:0] cnt_inc;

  // Two-flop synchronizers plus a history flop for edge detection, idle-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_m_q  <= 1'b1;
      cs_s_q  <= 1'b1;
      cs_h_q  <= 1'b1;
      sck_m_q <= 1'b1;
      sck_s_q <= 1'b1;
      sck_h_q <= 1'b1;
    end else begin
      cs_m_q  <= cs;
      cs_s_q  <= cs_m_q;
      cs_h_q  <= cs_s_q;
      sck_m_q <= sck;
      sck_s_q <= sck_m_q;
      sck_h_q <= sck_s_q;
    end
  end

  // Arms cs-fall detection only once the synchronizer reflects the pin and cs
  // is seen high, so a cs held low across reset never restarts a frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle_q <= '0;
      arm_q    <= 1'b0;
    end else begin
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && cs_s_q) arm_q <= 1'b1;
    end
  end

  assign cs_fall  = arm_q & cs_h_q & ~cs_s_q;
  assign cs_rise  = ~cs_h_q & cs_s_q;
  assign sck_fall = sck_h_q & ~sck_s_q;

  // Holding register written by local logic at any time.
  always_ff @(posedge clock) begin
    if (reset) hold_q <= '0;
    else if (data_valid) hold_q <= data;
  end

  // A write coinciding with the frame start is bypassed into the load.
  always_comb begin
    load_src   = data_valid ? data : hold_q;
    frame_word = FRAME_LEN'(load_src) << TRAIL;
    cnt_inc    = cnt_q + CW'(1);
  end

  // Frame state, shift register, bit counter and exit pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic; a cs rise takes priority over a same-cycle sck fall.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shreg_d = frame_word;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          done_d  = (cnt_q == CNT_FULL);
          abort_d = (cnt_q != CNT_FULL);
        end else if (sck_fall) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_FULL) state_d = DONE;
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
          done_d  = (cnt_q == CNT_FULL);
          abort_d = (cnt_q != CNT_FULL);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdo         = (state_q == SHIFT) & shreg_q[FRAME_LEN-1];
  assign sdo_oe      = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_pmod_als_spi_emulator.sv
// Bench for pmod_als_spi_emulator: a bit-banged SPI master drives frames,
// expected captures come from an arithmetic frame model and are matched by
// a monitor on each frame_done/frame_abort pulse.
module tb_pmod_als_spi_emulator;

  localparam int DW    = 8;
  localparam int FL    = 16;
  localparam int LZ    = 3;
  localparam int TRAIL = FL - LZ - DW;
  localparam int HALF  = 6;

  logic clock = 1'b0;
  logic reset, cs, sck, data_valid;
  logic [DW-1:0] data;
  logic sdo, sdo_oe, busy, frame_done, frame_abort;

  pmod_als_spi_emulator #(.DATA_WIDTH(DW), .LEAD_ZEROS(LZ), .FRAME_LEN(FL)) dut (
    .clock(clock), .reset(reset), .cs(cs), .sck(sck), .sdo(sdo), .sdo_oe(sdo_oe),
    .data(data), .data_valid(data_valid), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          done;
    logic [31:0] word;
    int          rise_cyc;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] cap_word;
  logic [DW-1:0] hold_m = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Capture seen by a master sampling sdo just before each sck fall.
  function automatic logic [31:0] exp_word(input logic [DW-1:0] d, input int n);
    int unsigned w;
    logic [31:0] r;
    w = int'(d) << TRAIL;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = r << 1;
      if (i < FL) r = r | 32'((w >> (FL - 1 - i)) & 1);
    end
    return r;
  endfunction

  // Monitor: every exit pulse consumes one expected frame.
  always @(negedge clock) begin
    if (frame_done || frame_abort) begin
      exp_t e;
      chk("pulse_exclusive", 32'(frame_done & frame_abort), 32'd0);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_pulse: got done=%0b abort=%0b expected none", frame_done, frame_abort);
      end else begin
        e = expq.pop_front();
        chk("frame_done", 32'(frame_done), 32'(e.done));
        chk("frame_word", cap_word, e.word);
        total++;
        if ((cyc - e.rise_cyc) < 3 || (cyc - e.rise_cyc) > 4) begin
          bad++;
          $display("FAIL pulse_latency: got %0d expected 3..4", cyc - e.rise_cyc);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic write_data(input logic [DW-1:0] v);
    @(negedge clock);
    data = v; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    hold_m = v;
  endtask

  // wr_at: -1 none, -2 write coinciding with cs-fall event, k>0 after k-th fall.
  task automatic run_frame(input int nfalls, input int wr_at, input logic [DW-1:0] wr_val);
    logic [DW-1:0] fdata;
    exp_t e;
    @(negedge clock);
    cs = 1'b0;
    if (wr_at == -2) begin
      wait_neg(2);
      data = wr_val; data_valid = 1'b1;
      @(negedge clock);
      data_valid = 1'b0;
      hold_m = wr_val;
      wait_neg(3);
    end else begin
      wait_neg(6);
    end
    fdata = hold_m;
    chk("busy_in_frame", 32'(busy), 32'd1);
    chk("oe_in_frame", 32'(sdo_oe), 32'd1);
    cap_word = '0;
    for (int i = 0; i < nfalls; i++) begin
      wait_neg(HALF);
      cap_word = {cap_word[30:0], sdo};
      sck = 1'b0;
      wait_neg(HALF);
      sck = 1'b1;
      if (wr_at == i + 1) begin
        @(negedge clock);
        data = wr_val; data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
        hold_m = wr_val;
      end
    end
    wait_neg(HALF);
    e.done = (nfalls >= FL);
    e.word = exp_word(fdata, nfalls);
    e.rise_cyc = cyc;
    expq.push_back(e);
    cs = 1'b1;
    for (int k = 0; k < 20 && expq.size() != 0; k++) @(negedge clock);
    chk("pulse_seen", 32'(expq.size()), 32'd0);
    expq.delete();
    chk("busy_after", 32'(busy), 32'd0);
    chk("oe_after", 32'(sdo_oe), 32'd0);
    chk("sdo_after", 32'(sdo), 32'd0);
    wait_neg(HALF);
  endtask

  task automatic reset_mid_frame();
    @(negedge clock);
    cs = 1'b0;
    wait_neg(6);
    for (int i = 0; i < 7; i++) begin
      wait_neg(HALF); sck = 1'b0;
      wait_neg(HALF); sck = 1'b1;
    end
    wait_neg(2);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_oe", 32'(sdo_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    reset = 1'b0;
    hold_m = '0;
    for (int i = 0; i < 9; i++) begin
      wait_neg(HALF); sck = 1'b0;
      wait_neg(HALF); sck = 1'b1;
      chk("post_rst_oe", 32'(sdo_oe), 32'd0);
      chk("post_rst_sdo", 32'(sdo), 32'd0);
    end
    @(negedge clock);
    cs = 1'b1;
    wait_neg(12);
  endtask

  initial begin
    int nf, wa;
    logic [DW-1:0] v;
    reset = 1'b1; cs = 1'b1; sck = 1'b1; data = '0; data_valid = 1'b0;
    wait_neg(3);
    chk("reset_sdo", 32'(sdo), 32'd0);
    chk("reset_oe", 32'(sdo_oe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_abort", 32'(frame_abort), 32'd0);
    reset = 1'b0;
    wait_neg(5);

    write_data(8'hA5); run_frame(16, -1, '0);
    write_data(8'h00); run_frame(16, -1, '0);
    write_data(8'hFF); run_frame(16, -1, '0);
    write_data(8'h81); run_frame(16, 6, 8'h3C);
    run_frame(16, -1, '0);
    run_frame(8, -1, '0);
    run_frame(16, -1, '0);
    run_frame(20, -1, '0);
    write_data(8'h11); run_frame(16, -2, 8'hC3);
    write_data(8'h5A); reset_mid_frame();
    run_frame(16, -1, '0);

    for (int t = 0; t < 10; t++) begin
      v = DW'($urandom);
      if ($urandom_range(0, 1) == 1) write_data(v);
      nf = int'($urandom_range(3, 20));
      case ($urandom_range(0, 2))
        0: wa = -1;
        1: wa = -2;
        default: wa = int'($urandom_range(1, 2));
      endcase
      run_frame(nf, wa, DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
